// File: rtl/pipe_reg_skid.sv
// Pipeline register with a one-entry skid buffer.
// The design provides a registered in_ready, a one-cycle forward latency and
// full throughput while streaming.
// Optional build macro: PIPE_REG_SKID_PERF_EN adds the stall_cnt and
// bubble_cnt performance counters.
module pipe_reg_skid #(
    parameter int          IR_W   = 32,
    parameter int          PC_W   = 32,
    parameter logic [31:0] NOP_IR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IR_W-1:0] in_ir,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IR_W-1:0] out_ir,
    output logic [PC_W-1:0] out_pc
`ifdef PIPE_REG_SKID_PERF_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     bubble_cnt
`endif
);

    localparam logic [IR_W-1:0] NOP_W = IR_W'(NOP_IR);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Initializers match the reset values, so the stage is empty before the first reset.
    state_t          state_q    = EMPTY;
    state_t          state_d;
    logic            in_ready_q = 1'b1;
    logic            in_ready_d;
    logic [IR_W-1:0] main_ir_q  = NOP_W;
    logic [IR_W-1:0] main_ir_d;
    logic [PC_W-1:0] main_pc_q  = '0;
    logic [PC_W-1:0] main_pc_d;
    logic            main_vld_q = 1'b0;
    logic            main_vld_d;
    logic [IR_W-1:0] skid_ir_q  = NOP_W;
    logic [IR_W-1:0] skid_ir_d;
    logic [PC_W-1:0] skid_pc_q  = '0;
    logic [PC_W-1:0] skid_pc_d;
    logic            skid_vld_q = 1'b0;
    logic            skid_vld_d;

    logic accept;
    logic complete;

    assign accept   = in_valid & in_ready_q;
    assign complete = main_vld_q & out_ready;

    // Next-state logic: occupancy FSM plus main/skid register loads.
    always_comb begin
        state_d    = state_q;
        main_ir_d  = main_ir_q;
        main_pc_d  = main_pc_q;
        main_vld_d = main_vld_q;
        skid_ir_d  = skid_ir_q;
        skid_pc_d  = skid_pc_q;
        skid_vld_d = skid_vld_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_ir_d  = in_ir;
                    main_pc_d  = in_pc;
                    main_vld_d = 1'b1;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (accept && complete) begin
                    main_ir_d = in_ir;
                    main_pc_d = in_pc;
                end else if (accept) begin
                    skid_ir_d  = in_ir;
                    skid_pc_d  = in_pc;
                    skid_vld_d = 1'b1;
                    state_d    = TWO;
                end else if (complete) begin
                    // Park NOP/0 in main so the idle outputs need no mux.
                    main_ir_d  = NOP_W;
                    main_pc_d  = '0;
                    main_vld_d = 1'b0;
                    state_d    = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a completion can occur.
                if (complete) begin
                    main_ir_d  = skid_ir_q;
                    main_pc_d  = skid_pc_q;
                    main_vld_d = skid_vld_q;
                    skid_ir_d  = NOP_W;
                    skid_pc_d  = '0;
                    skid_vld_d = 1'b0;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush overrides any same-cycle accept or completion.
        if (flush) begin
            main_ir_d  = NOP_W;
            main_pc_d  = '0;
            main_vld_d = 1'b0;
            skid_ir_d  = NOP_W;
            skid_pc_d  = '0;
            skid_vld_d = 1'b0;
            state_d    = EMPTY;
        end

        in_ready_d = (state_d != TWO);
    end

    // State and storage registers; reset has priority over flush and the handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_ir_q  <= NOP_W;
            main_pc_q  <= '0;
            main_vld_q <= 1'b0;
            skid_ir_q  <= NOP_W;
            skid_pc_q  <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_ir_q  <= main_ir_d;
            main_pc_q  <= main_pc_d;
            main_vld_q <= main_vld_d;
            skid_ir_q  <= skid_ir_d;
            skid_pc_q  <= skid_pc_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out_ir    = main_ir_q;
    assign out_pc    = main_pc_q;

`ifdef PIPE_REG_SKID_PERF_EN
    logic [15:0] stall_cnt_q  = '0;
    logic [15:0] bubble_cnt_q = '0;

    // Saturating stall/bubble counters; cleared by reset only, never by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (main_vld_q && !out_ready && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (!main_vld_q && bubble_cnt_q != 16'hFFFF)
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter IR_W, default 32, instruction field width.
REQ-002 Parameter PC_W, default 32, PC field width.
REQ-003 Parameter NOP_IR, default 32'h0000_0000, truncated to IR_W; IR value driven when no valid word is held.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  discard all held words; synchronous.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  stage can accept a word this cycle.
REQ-009 in_ir  input  IR_W  upstream instruction.
REQ-010 in_pc  input  PC_W  upstream PC.
REQ-011 out_valid  output  1  word presented downstream.
REQ-012 out_ready  input  1  downstream accepts the word this cycle.
REQ-013 out_ir  output  IR_W  presented instruction.
REQ-014 out_pc  output  PC_W  presented PC.
REQ-015 stall_cnt  output  16  cycles with out_valid=1 and out_ready=0; present only with PIPE_REG_SKID_PERF_EN.
REQ-016 bubble_cnt  output  16  cycles with out_valid=0; present only with PIPE_REG_SKID_PERF_EN.

Function
REQ-017 Storage SHALL be a main register and a skid register, each holding {ir, pc, valid}.
REQ-018 States SHALL be EMPTY (no word held), ONE (main only), and TWO (main and skid).
REQ-019 Acceptance SHALL occur when in_valid=1 and in_ready=1; presentation SHALL complete when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL be a register output equal to 1 in EMPTY and ONE and 0 in TWO; it SHALL have no combinational path from out_ready.
REQ-021 out_valid, out_ir and out_pc SHALL come directly from the main register.
REQ-022 Latency SHALL be 1 cycle: a word accepted at edge N is on out_* after edge N with out_valid=1.
REQ-023 EMPTY: on accept, go to ONE.
REQ-024 ONE: on accept with completion, load main from input and stay in ONE.
REQ-025 ONE: on accept without completion, load skid and go to TWO.
REQ-026 ONE: on completion with no accept, go to EMPTY.
REQ-027 TWO: on completion, move skid to main and go to ONE; no accept is possible in TWO.
REQ-028 Words SHALL leave in acceptance order, with none lost or duplicated.
REQ-029 While out_valid=0, out_ir SHALL equal NOP_IR and out_pc SHALL equal 0.
REQ-030 While out_valid=1 and out_ready=0, out_ir and out_pc SHALL hold stable.
REQ-031 flush=1 SHALL force EMPTY at the next edge, even when a same-cycle accept or completion occurs; the accepted word SHALL be discarded.
REQ-032 in_ready SHALL read 1 in the cycle after a flush.

Reset
REQ-033 reset SHALL take priority over flush and the handshakes.
REQ-034 reset=1 at an edge SHALL give EMPTY, out_valid=0, out_ir=NOP_IR, out_pc=0, in_ready=1 and skid cleared.
REQ-035 An assertion of reset while in TWO SHALL discard both words.
REQ-036 Initial values before the first reset SHALL equal the reset values.

Configuration
REQ-037 Macro PIPE_REG_SKID_PERF_EN, when defined, SHALL add stall_cnt and bubble_cnt.
REQ-038 Each counter SHALL increment once per qualifying cycle and saturate at 16'hFFFF.
REQ-039 Each counter SHALL clear on reset and SHALL be unaffected by flush.
REQ-040 With PIPE_REG_SKID_PERF_EN undefined, both ports and their logic SHALL be absent and the datapath SHALL be unchanged.

Verification
REQ-041 Streaming case: reset, then out_ready=1 and ir=0x8C010004/0x00221820/0xAC030008 (pc 0x3000/0x3004/0x3008) on consecutive cycles. Required: the same words appear one cycle later; in_ready stays 1.
REQ-042 Backpressure case: out_ready=0, accept A (0x3000) then B (0x3004). Required: in_ready=0 after B; out holds A; raising out_ready gives A then B; in_ready returns to 1.
REQ-043 Flush case: in TWO, assert flush with in_valid=1 and out_ready=1. Required: next cycle out_valid=0, out_ir=NOP_IR, out_pc=0, in_ready=1; neither word appears later.
REQ-044 Reset case: assert reset in TWO with flush=1. Required: reset state per REQ-034.
REQ-045 Random case: random in_valid/out_ready for 10000 cycles against a scoreboard. Required: order preserved and no loss.
REQ-046 Counter case (PIPE_REG_SKID_PERF_EN): hold out_valid=1 with out_ready=0 for 70000 cycles. Required: stall_cnt=16'hFFFF.
